// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_enc_pkg
//  Description : Shared constants for the RV32I instruction loader: op-class
//                codes used on the request port, 7-bit base opcodes, the
//                canonical NOP word, the alternate funct7 value and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

  // Op-class codes carried on req_op
  localparam logic [3:0] OP_R      = 4'd0;
  localparam logic [3:0] OP_I      = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LUI    = 4'd5;
  localparam logic [3:0] OP_AUIPC  = 4'd6;
  localparam logic [3:0] OP_JAL    = 4'd7;
  localparam logic [3:0] OP_JALR   = 4'd8;

  // RV32I base opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0,x0,0 - written in place of any rejected request
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // funct7 selecting sub / sra / srai
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } ld_state_e;

endpackage : rv_enc_pkg
`default_nettype wire

// File: rtl/rv_instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : rv_instr_pack
//  Description : Purely combinational RV32I encoder. Packs a field-level
//                request into a 32-bit instruction word and flags requests
//                that are illegal or whose immediate is out of range. An
//                illegal request yields the NOP word.
//  Ports       : i_op/i_funct3/i_alt/i_rd/i_rs1/i_rs2/i_imm - request fields
//                o_word    - encoded instruction (NOP when illegal)
//                o_illegal - request rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_instr_pack
  import rv_enc_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_alt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic        w_imm12_ok;  // fits 12-bit signed
  logic        w_imm13_ok;  // fits 13-bit signed, even
  logic        w_imm21_ok;  // fits 21-bit signed, even
  logic        w_shamt_ok;  // 0..31
  logic        w_upper_ok;  // low 12 bits clear
  logic        w_is_shift;
  logic [6:0]  w_funct7;
  logic [31:0] w_word;
  logic        w_illegal;

  // A value fits an N-bit signed field when every bit above N-1 equals the sign
  assign w_imm12_ok = (i_imm[31:11] == {21{i_imm[31]}});
  assign w_imm13_ok = (i_imm[31:12] == {20{i_imm[31]}}) && !i_imm[0];
  assign w_imm21_ok = (i_imm[31:20] == {12{i_imm[31]}}) && !i_imm[0];
  assign w_shamt_ok = (i_imm[31:5] == 27'd0);
  assign w_upper_ok = (i_imm[11:0] == 12'd0);
  assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
  assign w_funct7   = i_alt ? FUNCT7_ALT : 7'd0;

  always_comb begin
    w_word    = 32'd0;
    w_illegal = 1'b0;
    case (i_op)
      OP_R: begin
        w_word    = {w_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
        w_illegal = i_alt && !((i_funct3 == 3'b000) || (i_funct3 == 3'b101));
      end
      OP_I: begin
        if (w_is_shift) begin
          // shamt sits in imm[24:20]; alt selects srai via bit 30
          w_word    = {w_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_I};
          w_illegal = !w_shamt_ok || (i_alt && (i_funct3 != 3'b101));
        end else begin
          w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_I};
          w_illegal = !w_imm12_ok || i_alt;
        end
      end
      OP_LOAD: begin
        w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
        w_illegal = !w_imm12_ok || (i_funct3 == 3'b011) ||
                    (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
      end
      OP_STORE: begin
        w_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
        w_illegal = !w_imm12_ok || (i_funct3 > 3'b010);
      end
      OP_BRANCH: begin
        w_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], OPC_BRANCH};
        w_illegal = !w_imm13_ok || (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
      end
      OP_LUI: begin
        w_word    = {i_imm[31:12], i_rd, OPC_LUI};
        w_illegal = !w_upper_ok;
      end
      OP_AUIPC: begin
        w_word    = {i_imm[31:12], i_rd, OPC_AUIPC};
        w_illegal = !w_upper_ok;
      end
      OP_JAL: begin
        w_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
        w_illegal = !w_imm21_ok;
      end
      OP_JALR: begin
        w_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_JALR};
        w_illegal = !w_imm12_ok || (i_funct3 != 3'b000);
      end
      default: begin
        w_word    = 32'd0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign o_word    = w_illegal ? NOP_WORD : w_word;
  assign o_illegal = w_illegal;

endmodule : rv_instr_pack
`default_nettype wire

// File: rtl/rv_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rv_instr_loader
//  Description : Session-based RV32I instruction loader. Accepts field-level
//                requests, encodes each through rv_instr_pack and writes the
//                words to consecutive instruction-memory addresses.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                start, base_addr       - open a session at base_addr & ~3
//                busy, done             - session active / end pulse
//                req_valid, req_ready,
//                req_last, req_*        - request handshake and fields
//                im_valid, im_ready,
//                im_addr, im_wdata      - instruction-memory write port
//                err                    - sticky illegal-request flag
//                word_count             - words written this session
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_instr_loader
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [3:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              im_valid,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic              req_ready_q, req_ready_d;
  logic              im_valid_q, im_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       w_pack_word;
  logic              w_pack_illegal;

  rv_instr_pack u_pack (
    .i_op      (req_op),
    .i_funct3  (req_funct3),
    .i_alt     (req_alt),
    .i_rd      (req_rd),
    .i_rs1     (req_rs1),
    .i_rs2     (req_rs2),
    .i_imm     (req_imm),
    .o_word    (w_pack_word),
    .o_illegal (w_pack_illegal)
  );

  always_comb begin
    state_d      = state_q;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    last_d       = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          im_addr_d    = base_addr & ~ADDR_W'(3);
          err_d        = 1'b0;
          word_count_d = '0;
          state_d      = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (req_valid && req_ready_q) begin
          im_wdata_d = w_pack_word;
          last_d     = req_last;
          err_d      = err_q | w_pack_illegal;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (im_ready) begin
          im_addr_d    = im_addr_q + ADDR_W'(4);
          word_count_d = word_count_q + ADDR_W'(1);
          state_d      = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state, so they are
    // glitch-free and req_ready / im_valid are mutually exclusive by design.
    req_ready_d = (state_d == ST_ACCEPT);
    im_valid_d  = (state_d == ST_WRITE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      im_addr_q    <= '0;
      im_wdata_q   <= 32'd0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      last_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      im_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      last_q       <= last_d;
      req_ready_q  <= req_ready_d;
      im_valid_q   <= im_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign req_ready  = req_ready_q;
  assign im_valid   = im_valid_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule : rv_instr_loader
`default_nettype wire

// File: tb/tb_rv_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_instr_loader
//  Description : Self-checking bench for rv_instr_loader. Expected writes are
//                queued when a request is issued and popped by an independent
//                write-port monitor. Random requests are checked against an
//                arithmetic RV32I encoding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_instr_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done;
  logic          req_valid, req_ready, req_last;
  logic [3:0]    req_op;
  logic [2:0]    req_funct3;
  logic          req_alt;
  logic [4:0]    req_rd, req_rs1, req_rs2;
  logic [31:0]   req_imm;
  logic          im_valid;
  logic          im_ready = 1'b0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          err;
  logic [AW-1:0] word_count;

  rv_instr_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_last   (req_last),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .req_alt    (req_alt),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .im_valid   (im_valid),
    .im_ready   (im_ready),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 1;   // 0 random, 1 always ready, 2 held low
  logic [AW-1:0] m_addr;
  logic          m_err;
  int            m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] at(input logic [31:0] v, input int pos);
    return v << pos;
  endfunction

  function automatic logic [32:0] model_encode(input req_t r);
    logic [31:0] u, w, base;
    int          s;
    logic        ill;
    u = r.imm;
    s = r.imm;
    ill = 1'b0;
    base = at(r.rd, 7) | at(r.f3, 12) | at(r.rs1, 15);
    w = 32'h0;
    case (r.op)
      4'd0: begin
        ill = r.alt && !(r.f3 == 3'd0 || r.f3 == 3'd5);
        w = 32'h33 | base | at(r.rs2, 20) | (r.alt ? 32'h4000_0000 : 32'h0);
      end
      4'd1: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
          ill = (u > 32'd31) || (r.alt && r.f3 != 3'd5);
          w = 32'h13 | base | at(u % 32, 20) | (r.alt ? 32'h4000_0000 : 32'h0);
        end else begin
          ill = r.alt || s < -2048 || s > 2047;
          w = 32'h13 | base | at(u % 4096, 20);
        end
      end
      4'd2: begin
        ill = r.f3 == 3'd3 || r.f3 == 3'd6 || r.f3 == 3'd7 || s < -2048 || s > 2047;
        w = 32'h03 | base | at(u % 4096, 20);
      end
      4'd3: begin
        ill = r.f3 > 3'd2 || s < -2048 || s > 2047;
        w = 32'h23 | at(u % 32, 7) | at(r.f3, 12) | at(r.rs1, 15) | at(r.rs2, 20)
            | at((u / 32) % 128, 25);
      end
      4'd4: begin
        ill = r.f3 == 3'd2 || r.f3 == 3'd3 || s < -4096 || s > 4094 || (u % 2 != 0);
        w = 32'h63 | at((u / 2048) % 2, 7) | at((u / 2) % 16, 8) | at(r.f3, 12)
            | at(r.rs1, 15) | at(r.rs2, 20) | at((u / 32) % 64, 25) | at((u / 4096) % 2, 31);
      end
      4'd5, 4'd6: begin
        ill = (u % 4096) != 0;
        w = ((u / 4096) * 4096) | at(r.rd, 7) | ((r.op == 4'd5) ? 32'h37 : 32'h17);
      end
      4'd7: begin
        ill = s < -1048576 || s > 1048574 || (u % 2 != 0);
        w = 32'h6F | at(r.rd, 7) | at((u / 4096) % 256, 12) | at((u / 2048) % 2, 20)
            | at((u / 2) % 1024, 21) | at((u / 1048576) % 2, 31);
      end
      4'd8: begin
        ill = r.f3 != 3'd0 || s < -2048 || s > 2047;
        w = 32'h67 | base | at(u % 4096, 20);
      end
      default: ill = 1'b1;
    endcase
    return {ill, ill ? 32'h0000_0013 : w};
  endfunction

  function automatic req_t mk(input int op, input int f3, input int alt, input int rd,
                              input int rs1, input int rs2, input logic [31:0] imm);
    req_t r;
    r.op = 4'(op); r.f3 = 3'(f3); r.alt = 1'(alt);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   bl[16] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095,
                      4096, -1048576, 1048574, 1048575, 1048576, 32, 31, 0};
    r.op  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    r.f3  = 3'($urandom);
    r.alt = ($urandom_range(0, 3) == 0);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    case ($urandom_range(0, 5))
      0: r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      1: r.imm = 32'(bl[$urandom_range(0, 15)]);
      2: r.imm = $urandom;
      3: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'h1;
      4: r.imm = $urandom & 32'hFFFF_F000;
      default: r.imm = 32'($urandom_range(0, 40));
    endcase
    return r;
  endfunction

  // ---------------- im_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       im_ready = ($urandom_range(0, 3) != 0);
      1:       im_ready = 1'b1;
      default: im_ready = 1'b0;
    endcase
  end

  // ---------------- write-port monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_valid && req_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_valid_overlap: got req_ready=1 im_valid=1, expected not both");
      end
      if (im_valid && im_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", im_addr, im_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 32'(im_addr), 32'(mon_e.addr));
          chk("write_data", im_wdata, mon_e.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_im_valid"}, 32'(im_valid), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    m_addr = {b[AW-1:2], 2'b00};
    m_err = 1'b0;
    m_n = 0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    chk("start_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic send_req(input req_t r, input logic last, input logic [31:0] exp_w,
                          input logic exp_ill);
    bit ok;
    @(posedge clk); #1;
    req_op = r.op; req_funct3 = r.f3; req_alt = r.alt;
    req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
    req_last = last;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got req_ready=0 for 400 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back('{addr: m_addr, data: exp_w});
    m_addr = m_addr + AW'(4);
    m_n++;
    m_err = m_err | exp_ill;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_imm = $urandom;
    req_op = 4'($urandom);
  endtask

  task automatic send_model(input req_t r, input logic last);
    logic [32:0] e;
    e = model_encode(r);
    send_req(r, last, e[31:0], e[32]);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 for 1000 cycles, expected 1");
      return;
    end
    chk("done_word_count", 32'(word_count), 32'(m_n % (1 << AW)));
    chk("done_err", 32'(err), 32'(m_err));
    chk("done_writes_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    req_valid = 1'b0; req_last = 1'b0; req_op = '0; req_funct3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    m_addr = '0; m_err = 1'b0; m_n = 0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    #2 rst_n = 1'b1;

    // add / sub pair
    rdy_mode = 1;
    do_start(12'h100);
    send_req(mk(0, 0, 0, 3, 1, 2, 32'd0), 1'b0, 32'h0020_81B3, 1'b0);
    send_req(mk(0, 0, 1, 3, 1, 2, 32'd0), 1'b1, 32'h4020_81B3, 1'b0);
    wait_done();

    // one of each main format
    do_start(12'h000);
    send_req(mk(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF), 1'b0, 32'hFFF0_0093, 1'b0);
    send_req(mk(4, 0, 0, 0, 1, 2, 32'd8),         1'b0, 32'h0020_8463, 1'b0);
    send_req(mk(7, 0, 0, 1, 0, 0, 32'd2048),      1'b0, 32'h0010_00EF, 1'b0);
    send_req(mk(5, 0, 0, 5, 0, 0, 32'h1234_5000), 1'b1, 32'h1234_52B7, 1'b0);
    wait_done();

    // illegal requests become NOP and raise err one cycle after handshake
    do_start(12'h080);
    send_req(mk(4, 0, 0, 0, 1, 2, 32'd7), 1'b0, 32'h0000_0013, 1'b1);
    @(negedge clk);
    chk("err_after_illegal", 32'(err), 32'd1);
    send_req(mk(1, 0, 0, 1, 0, 0, 32'd2048), 1'b1, 32'h0000_0013, 1'b1);
    wait_done();

    // write stall: outputs held while im_ready is low
    rdy_mode = 2;
    do_start(12'h200);
    send_req(mk(0, 0, 0, 3, 1, 2, 32'd0), 1'b1, 32'h0020_81B3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_im_valid", 32'(im_valid), 32'd1);
      chk("stall_im_addr", 32'(im_addr), 32'h200);
      chk("stall_im_wdata", im_wdata, 32'h0020_81B3);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rdy_mode = 1;
    wait_done();

    // address wrap
    do_start(12'hFFD);
    send_model(mk(1, 0, 0, 2, 3, 0, 32'd5), 1'b0);
    send_model(mk(3, 2, 0, 0, 3, 4, 32'hFFFF_FFF0), 1'b1);
    wait_done();

    // reset during a pending write aborts it
    rdy_mode = 2;
    do_start(12'h300);
    send_req(mk(0, 0, 0, 3, 1, 2, 32'd0), 1'b1, 32'h0020_81B3, 1'b0);
    @(negedge clk);
    chk("pre_reset_im_valid", 32'(im_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    do_start(12'h040);
    send_req(mk(0, 0, 0, 3, 1, 2, 32'd0), 1'b0, 32'h0020_81B3, 1'b0);
    send_req(mk(0, 0, 1, 3, 1, 2, 32'd0), 1'b1, 32'h4020_81B3, 1'b0);
    wait_done();

    // randomized sessions with random stalls and gaps
    rdy_mode = 0;
    for (int s = 0; s < 10; s++) begin
      int n;
      n = $urandom_range(1, 12);
      do_start((s % 3 == 0) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        send_model(rand_req(), k == n - 1);
      end
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rv_instr_loader
`default_nettype wire

// File: doc/rv_instr_loader.md
# rv_instr_loader

Sequential instruction encoder/loader for the RV32I core: the inverse of the core's control-unit decode. Accepts field-level instruction requests (op class, funct3, alt bit, registers, immediate) over a valid/ready handshake, packs each into a 32-bit RV32I word with legality and range checks, and writes the words to consecutive instruction-memory addresses over a valid/ready write port. It is used by the boot/self-test path to fill instruction memory before the core is released.

## Interface
Parameters:
- ADDR_W, 12, instruction-memory byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; bits [1:0] forced to 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the session ends.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_last  in  1  final request of the session.
- req_op  in  4  op class: R=0, I=1, LOAD=2, STORE=3, BRANCH=4, LUI=5, AUIPC=6, JAL=7, JALR=8.
- req_funct3  in  3  funct3 field.
- req_alt  in  1  selects funct7=0100000 (sub, sra, srai).
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  32  byte-level immediate or offset, signed except for LUI/AUIPC.
- im_valid  out  1  write valid.
- im_ready  in  1  memory accepts write.
- im_addr  out  ADDR_W  write byte address.
- im_wdata  out  32  encoded instruction.
- err  out  1  sticky; a request was illegal or out of range.
- word_count  out  ADDR_W  words written this session.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: req_ready=0, im_valid=0. On start: im_addr<=base_addr&~3, err<=0, word_count<=0, go to ACCEPT.
- ACCEPT: req_ready=1. On handshake: register packed word into im_wdata, latch req_last, go to WRITE.
- WRITE: im_valid=1; im_addr and im_wdata held stable. On im_ready: im_addr+=4 (wraps modulo 2^ADDR_W), word_count+=1, then DONE if latched last, else ACCEPT.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored while busy.
- Packing: standard RV32I R/I/S/B/U/J formats. Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Range rules, each violation is illegal:
  - I/LOAD/STORE/JALR: imm in [-2048, 2047].
  - BRANCH: imm in [-4096, 4094] and imm[0]=0.
  - JAL: imm in [-2^20, 2^20-2] and imm[0]=0.
  - LUI/AUIPC: imm[11:0]=0; upper 20 bits are used.
  - Shift-immediates (I with funct3 001/101): imm[31:5]=0; alt sets bits [31:25]=0100000.
- Illegal combinations:
  - req_op>8.
  - alt on R with funct3 not 000/101.
  - alt on I with funct3 not 101.
  - funct3 010/011 on BRANCH.
  - funct3 011/110/111 on LOAD.
  - funct3>010 on STORE.
  - funct3≠0 on JALR.
- An illegal request is still written, as NOP 0x00000013, and sets err. The session continues.

## Timing
- Reset values: req_ready=0, im_valid=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, word_count=0; state IDLE.
- Reset asserted mid-session aborts at once; any pending write is dropped.
- Request-to-im_valid latency: 1 cycle. Peak throughput: 1 word per 2 cycles.
- req_ready and im_valid are never high in the same cycle.
- im_ready held low stalls WRITE indefinitely with no output change.
- err rises the cycle after the offending handshake and clears only on start.

## Structure
- Package rv_enc_pkg holds: op-class codes, 7-bit opcode constants, NOP constant, funct7 alt constant.
- Sub-module rv_instr_pack: purely combinational packing and legality check (req fields -> word, illegal). The top module holds the FSM, address counter and registers.

## Test plan
- add x3,x1,x2 then sub x3,x1,x2 (last), base 0x100 -> writes 0x002081B3 @0x100, 0x402081B3 @0x104; done pulse; word_count=2; err=0.
- addi x1,x0,-1; beq x1,x2,+8; jal x1,+2048; lui x5,0x12345000 -> 0xFFF00093, 0x00208463, 0x001000EF, 0x123452B7.
- beq with imm=7, and addi with imm=2048 -> both written as 0x00000013; err=1 after the first; session completes.
- im_ready low for 3 cycles in WRITE -> im_valid, im_addr, im_wdata stable; req_ready=0; write completes on the first im_ready.
- ADDR_W=8, base 0xFD, two requests -> addresses 0xFC then 0x00 (wrap).
- rst_n pulsed low during WRITE -> all outputs return to reset values immediately; a new start works normally.
